// File: rtl/writeback_stage.sv
// writeback_stage: final stage of the 64-bit core and the only writer of the
// integer register file. Arbitrates between the EX result channel and the
// load-return channel, formats load data, and registers one write per cycle.
// Optional feature: define WB_INSTRET_EN to add the instret_o retire counter.
//
// Handshake: a channel transfers in a cycle where its valid and its ready are
// both 1. Ready is a combinational grant and never depends on the other side
// being ready. At most one channel transfers per cycle. Results appear on the
// register-file write port one cycle after the transfer.
module writeback_stage #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [2:0]      mem_byte_off_i,
  output logic [4:0]      rd_addr_o,
  output logic            wr_en_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic            load_err_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret_o
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      starve_cnt;
  logic [3:0]      starve_cnt_next;
  logic            grant_ex;
  logic            grant_mem;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;
  logic            misaligned;
  logic            illegal;
  logic            load_err;

  // Arbitration: loads win by default, EX is forced through once it has been
  // starved for LIMIT consecutive cycles.
  always_comb begin
    grant_ex    = ex_valid_i && (!mem_valid_i || (starve_cnt == LIMIT));
    grant_mem   = mem_valid_i && !grant_ex;
    ex_ready_o  = grant_ex;
    mem_ready_o = grant_mem;
  end

  // Starve counter next value: clear when EX is served or idle, else count
  // losses up to the limit.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!ex_valid_i || grant_ex) begin
      starve_cnt_next = 4'd0;
    end else if (grant_mem && (starve_cnt != LIMIT)) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end

  assign shifted = mem_rdata_i >> {mem_byte_off_i, 3'b000};

  // Load alignment, extension and error detection.
  always_comb begin
    load_data  = shifted;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (mem_funct3_i)
      3'b000:  load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b011:  load_data = shifted;
      3'b100:  load_data = {{(XLEN-8){1'b0}},  shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: illegal   = 1'b1;
    endcase
    case (mem_funct3_i[1:0])
      2'b01:   misaligned = mem_byte_off_i[0];
      2'b10:   misaligned = (mem_byte_off_i[1:0] != 2'b00);
      2'b11:   misaligned = (mem_byte_off_i != 3'b000);
      default: misaligned = 1'b0;
    endcase
    load_err = misaligned || illegal;
  end

  // Register-file write port: one registered write per granted transfer;
  // rd = 0 and faulting loads are consumed without writing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_o  <= 5'd0;
      wr_en_o    <= 1'b0;
      wr_data_o  <= '0;
      load_err_o <= 1'b0;
    end else if (grant_ex) begin
      rd_addr_o  <= ex_rd_addr_i;
      wr_en_o    <= (ex_rd_addr_i != 5'd0);
      wr_data_o  <= ex_data_i;
      load_err_o <= 1'b0;
    end else if (grant_mem) begin
      rd_addr_o  <= mem_rd_addr_i;
      wr_en_o    <= (mem_rd_addr_i != 5'd0) && !load_err;
      wr_data_o  <= load_data;
      load_err_o <= load_err;
    end else begin
      wr_en_o    <= 1'b0;
      load_err_o <= 1'b0;
    end
  end

`ifdef WB_INSTRET_EN
  // Retire counter: one count per granted transfer, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_o <= 64'd0;
    end else if (grant_ex || grant_mem) begin
      instret_o <= instret_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed bench for writeback_stage with a scoreboard.
// The driver pushes expected register-file activity into exp_q; a monitor
// pops and compares whenever the DUT shows a write or a load error.
// Entry layout: {wr_en, load_err, rd_addr[4:0], wr_data[63:0]}.
module tb_writeback_stage;

  localparam int W = 71;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd_addr;
  logic [63:0] ex_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd_addr;
  logic [63:0] mem_rdata;
  logic [2:0]  mem_funct3;
  logic [2:0]  mem_byte_off;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        load_err;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] instret_before;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  writeback_stage #(.XLEN(64), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid_i     (ex_valid),
    .ex_ready_o     (ex_ready),
    .ex_rd_addr_i   (ex_rd_addr),
    .ex_data_i      (ex_data),
    .mem_valid_i    (mem_valid),
    .mem_ready_o    (mem_ready),
    .mem_rd_addr_i  (mem_rd_addr),
    .mem_rdata_i    (mem_rdata),
    .mem_funct3_i   (mem_funct3),
    .mem_byte_off_i (mem_byte_off),
    .rd_addr_o      (rd_addr),
    .wr_en_o        (wr_en),
    .wr_data_o      (wr_data),
    .load_err_o     (load_err)
`ifdef WB_INSTRET_EN
    ,
    .instret_o      (instret)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_write(input logic [4:0] rd, input logic [63:0] d);
    return {1'b1, 1'b0, rd, d};
  endfunction

  function automatic logic [W-1:0] exp_error(input logic [4:0] rd);
    return {1'b0, 1'b1, rd, 64'h0};
  endfunction

  // Driver: apply one cycle of inputs, check the ready pair, record expectation.
  task automatic drive(input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                       input logic [2:0] f3, input logic [2:0] off,
                       input logic exp_er, input logic exp_mr,
                       input logic push, input logic [W-1:0] exp, input string name);
    @(posedge clk);
    #1;
    ex_valid = ev; ex_rd_addr = erd; ex_data = ed;
    mem_valid = mv; mem_rd_addr = mrd; mem_rdata = md;
    mem_funct3 = f3; mem_byte_off = off;
    @(negedge clk);
    check({name, " ready"}, {{(W-2){1'b0}}, ex_ready, mem_ready}, {{(W-2){1'b0}}, exp_er, exp_mr});
    if (push) exp_q.push_back(exp);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, '0, "idle");
  endtask

  task automatic ex_op(input logic [4:0] rd, input logic [63:0] d, input logic push, input string name);
    drive(1'b1, rd, d, 1'b0, 5'd0, 64'h0, 3'd0, 3'd0, 1'b1, 1'b0, push, exp_write(rd, d), name);
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [63:0] md, input logic [2:0] f3,
                         input logic [2:0] off, input logic push, input logic [W-1:0] exp,
                         input string name);
    drive(1'b0, 5'd0, 64'h0, 1'b1, rd, md, f3, off, 1'b0, 1'b1, push, exp, name);
  endtask

  task automatic both_op(input logic exp_ex_wins, input string name);
    drive(1'b1, 5'd10, 64'hAAAA_0000_0000_000A, 1'b1, 5'd11, 64'hBBBB_0000_0000_000B, 3'b011, 3'd0,
          exp_ex_wins, !exp_ex_wins, 1'b1,
          exp_ex_wins ? exp_write(5'd10, 64'hAAAA_0000_0000_000A)
                      : exp_write(5'd11, 64'hBBBB_0000_0000_000B), name);
  endtask

  // Monitor / scoreboard: compare every visible write or load error.
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && (wr_en || load_err)) begin
        got = {wr_en, load_err, rd_addr, wr_data};
        if (exp_q.size() == 0) begin
          check("unexpected_output", got, '0);
        end else begin
          exp = exp_q.pop_front();
          if (exp[W-2]) got[63:0] = 64'h0;
          check("writeback", got, exp);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_rd_addr = 5'd0; ex_data = 64'h0;
    mem_valid = 1'b0; mem_rd_addr = 5'd0; mem_rdata = 64'h0;
    mem_funct3 = 3'd0; mem_byte_off = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {wr_en, load_err, rd_addr, wr_data}, '0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // EX write, then a burst of formatted loads back to back
    ex_op(5'd5, 64'h1234, 1'b1, "ex_rd5");
    load_op(5'd3, 64'h8000_0000_0000_0000, 3'b000, 3'd7, 1'b1, exp_write(5'd3, 64'hFFFF_FFFF_FFFF_FF80), "lb");
    load_op(5'd3, 64'h8000_0000_0000_0000, 3'b100, 3'd7, 1'b1, exp_write(5'd3, 64'h0000_0000_0000_0080), "lbu");
    load_op(5'd4, 64'h0000_0000_8765_0000, 3'b001, 3'd2, 1'b1, exp_write(5'd4, 64'hFFFF_FFFF_FFFF_8765), "lh");
    load_op(5'd4, 64'h0000_0000_8765_0000, 3'b101, 3'd2, 1'b1, exp_write(5'd4, 64'h0000_0000_0000_8765), "lhu");
    load_op(5'd6, 64'h7FFF_0000_0000_0000, 3'b001, 3'd6, 1'b1, exp_write(5'd6, 64'h0000_0000_0000_7FFF), "lh_pos");
    load_op(5'd7, 64'hDEAD_BEEF_0000_0000, 3'b010, 3'd4, 1'b1, exp_write(5'd7, 64'hFFFF_FFFF_DEAD_BEEF), "lw");
    load_op(5'd7, 64'hDEAD_BEEF_0000_0000, 3'b110, 3'd4, 1'b1, exp_write(5'd7, 64'h0000_0000_DEAD_BEEF), "lwu");
    load_op(5'd8, 64'h0123_4567_89AB_CDEF, 3'b011, 3'd0, 1'b1, exp_write(5'd8, 64'h0123_4567_89AB_CDEF), "ld");
    idle();

    // Faulting loads: accepted, no write, one-cycle error pulse each
    load_op(5'd9, 64'h1111_2222_3333_4444, 3'b010, 3'd2, 1'b1, exp_error(5'd9), "lw_misaligned");
    idle();
    load_op(5'd9, 64'h1111_2222_3333_4444, 3'b111, 3'd0, 1'b1, exp_error(5'd9), "illegal_f3");
    load_op(5'd9, 64'h1111_2222_3333_4444, 3'b001, 3'd1, 1'b1, exp_error(5'd9), "lh_misaligned");
    load_op(5'd9, 64'h1111_2222_3333_4444, 3'b011, 3'd4, 1'b1, exp_error(5'd9), "ld_misaligned");
    load_op(5'd0, 64'h1111_2222_3333_4444, 3'b011, 3'd0, 1'b0, '0, "load_rd0");
    idle();

    // Contention: loads win four times, then EX is forced through
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) both_op(1'b0, "arb_mem");
      both_op(1'b1, "arb_ex");
    end
    idle();

    // rd = 0 EX op is consumed without a write
    ex_op(5'd0, 64'hFF, 1'b0, "ex_rd0");
`ifdef WB_INSTRET_EN
    instret_before = instret;
    idle();
    check("instret_rd0", {7'd0, instret}, {7'd0, instret_before + 64'd1});
`else
    idle();
`endif

    // Reset in the cycle after a grant, with the starve counter part-way up
    both_op(1'b0, "pre_reset_mem");
    @(posedge clk);
    #1;
    ex_valid = 1'b1; mem_valid = 1'b1;
    @(negedge clk);
    check("pre_reset_ready", {{(W-2){1'b0}}, ex_ready, mem_ready}, {{(W-2){1'b0}}, 2'b01});
    @(posedge clk);
    #1;
    ex_valid = 1'b0; mem_valid = 1'b0;
    check("pre_reset_wr_en", {{(W-1){1'b0}}, wr_en}, {{(W-1){1'b0}}, 1'b1});
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {wr_en, load_err, rd_addr, wr_data}, '0);
    @(negedge clk);
    reset = 1'b0;
    idle();
`ifdef WB_INSTRET_EN
    check("instret_after_reset", {7'd0, instret}, '0);
`endif
    // Starve counter must restart from 0: four load wins before EX again
    for (int i = 0; i < 4; i++) both_op(1'b0, "post_reset_mem");
    both_op(1'b1, "post_reset_ex");
    idle();
    idle();

    check("queue_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Ready outputs are never both high
  always @(negedge clk) begin
    if (ex_ready && mem_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL both_ready: got ex=%b mem=%b expected not both 1", ex_ready, mem_ready);
    end
  end

endmodule
